// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit for EX stage.    |
// | Option: MULDIV_EARLY_OUT_EN skips iteration for trivially-known results.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rv_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int c_steps = XLEN / UNROLL;
  localparam int c_cw    = $clog2(c_steps + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [c_cw-1:0]   cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic              bzero_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [2*XLEN-1:0] w_step;
  logic [XLEN:0]     w_rtrial, w_sum;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_res;

  // MULHSU treats only rs1 as signed; all *U variants are unsigned.
  always_comb begin
    w_b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    w_a_signed = w_b_signed || (funct3 == 3'b010);
    w_sa       = w_a_signed & op_a[XLEN-1];
    w_sb       = w_b_signed & op_b[XLEN-1];
    w_abs_a    = w_sa ? -op_a : op_a;
    w_abs_b    = w_sb ? -op_b : op_b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic              w_early;
  logic              w_ovf;
  logic [2*XLEN-1:0] w_early_acc;

  // Accumulator is preloaded so the FIX stage yields the architectural result.
  always_comb begin
    w_ovf = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
            (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    if (funct3[2]) begin
      w_early     = (op_b == '0) || w_ovf;
      w_early_acc = (op_b == '0) ? {w_abs_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, w_abs_a};
    end else begin
      w_early     = (op_a == '0) || (op_b == '0);
      w_early_acc = '0;
    end
  end
`endif

  // Upper half of acc is product-high / remainder, lower half is multiplier / quotient.
  always_comb begin
    w_step   = acc_q;
    w_rtrial = '0;
    w_sum    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (f3_q[2]) begin
        w_rtrial               = {w_step[2*XLEN-1:XLEN], w_step[XLEN-1]};
        w_step[XLEN-1:0]       = {w_step[XLEN-2:0], 1'b0};
        if (w_rtrial >= {1'b0, mcand_q}) begin
          w_rtrial  = w_rtrial - {1'b0, mcand_q};
          w_step[0] = 1'b1;
        end
        w_step[2*XLEN-1:XLEN] = w_rtrial[XLEN-1:0];
      end else begin
        w_sum  = {1'b0, w_step[2*XLEN-1:XLEN]} + (w_step[0] ? {1'b0, mcand_q} : '0);
        w_step = {w_sum, w_step[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    w_prod = neg_q ? -acc_q : acc_q;
    w_quo  = bzero_q ? {XLEN{1'b1}} : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    w_rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 w_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = w_quo;
      default:                w_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            f3_q      <= funct3;
            rd_q      <= rd_in;
            neg_q     <= w_sa ^ w_sb;
            rem_neg_q <= w_sa;
            bzero_q   <= (op_b == '0);
            mcand_q   <= funct3[2] ? w_abs_b : w_abs_a;
            acc_q     <= {{XLEN{1'b0}}, (funct3[2] ? w_abs_a : w_abs_b)};
            busy_q    <= 1'b1;
            cnt_q     <= c_cw'(c_steps);
            state_q   <= S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              acc_q   <= w_early_acc;
              cnt_q   <= '0;
              state_q <= S_FIX;
            end
`endif
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= w_step;
            cnt_q <= cnt_q - c_cw'(1);
            if (cnt_q == c_cw'(1)) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= w_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv_muldiv_unit: vector table + scoreboard bench for rv_muldiv_unit.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rv_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [4:0]  rd_out, rd_out4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        tbl[16];
  logic [31:0] last_res = '0;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  rv_muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_in(rd_in), .flush(flush), .busy(busy4), .done(done4),
    .result(result4), .rd_out(rd_out4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'(int'(a));
    longint      sb = longint'(int'(b));
    longint      ua = longint'(a);
    longint      ub = longint'(b);
    logic [63:0] p;
    int          ia = int'(a);
    int          ib = int'(b);
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000:  begin p = 64'(sa * sb); return p[31:0];  end
      3'b001:  begin p = 64'(sa * sb); return p[63:32]; end
      3'b010:  begin p = 64'(sa * ub); return p[63:32]; end
      3'b011:  begin p = 64'(ua * ub); return p[63:32]; end
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("result", {32'h0, result}, {32'h0, e.res});
        check("rd_out", {59'h0, rd_out}, {59'h0, e.rd});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    int exp_lat;
    sb_t e;
    exp_lat = (v.special && EARLY) ? 2 : 34;
    @(negedge clk);
    funct3 = v.f3; op_a = v.a; op_b = v.b; rd_in = v.rd; start = 1'b1;
    e.res = v.exp; e.rd = v.rd;
    sb_q.push_back(e);
    last_res = v.exp;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_after_start", {63'h0, busy}, 64'd1);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_at_done", {63'h0, busy}, 64'd0);
  endtask

  initial begin
    int   lat4;
    int   ndone4;
    vec_t v;

    tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0};
    tbl[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 1'b0};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 1'b0};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        1'b0};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         1'b0};
    tbl[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b1};
    tbl[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0,         1'b1};
    tbl[10] = '{3'b101, 32'd100,       32'd0,         5'd15, 32'hFFFF_FFFF, 1'b1};
    tbl[11] = '{3'b111, 32'd100,       32'd0,         5'd16, 32'd100,       1'b1};
    tbl[12] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         5'd18, 32'hFFFF_FFFB, 1'b1};
    tbl[14] = '{3'b000, 32'd0,         32'd12345,     5'd19, 32'd0,         1'b1};
    tbl[15] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy",   {63'h0, busy},   64'd0);
    check("rst_done",   {63'h0, done},   64'd0);
    check("rst_result", {32'h0, result}, 64'd0);
    check("rst_rd_out", {59'h0, rd_out}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Random operations checked against the behavioural model.
    for (int i = 0; i < 6; i++) begin
      v.f3 = 3'($urandom_range(0, 7));
      v.a  = $urandom;
      v.b  = $urandom;
      v.rd = 5'($urandom_range(1, 31));
      v.exp = model(v.f3, v.a, v.b);
      v.special = v.f3[2] ? ((v.b == 0) || (v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF &&
                                            !v.f3[0]))
                          : ((v.a == 0) || (v.b == 0));
      run_vec(v);
    end

    // Flush mid-divide: no done, result unchanged, then a fresh MUL.
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd10; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("busy_before_flush", {63'h0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("busy_after_flush",   {63'h0, busy},   64'd0);
    check("done_after_flush",   {63'h0, done},   64'd0);
    check("result_after_flush", {32'h0, result}, {32'h0, last_res});
    v = '{3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0};
    run_vec(v);

    // flush together with start in IDLE accepts nothing.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'h0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // UNROLL=4: latency, ignored starts while busy, single done.
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'h1234_5678; op_b = 32'h10; rd_in = 5'd9; start4 = 1'b1;
    lat4 = 0; ndone4 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start4 = (k == 2) || (k == 4);
      op_a   = 32'hDEAD_BEEF;
      rd_in  = 5'd30;
      if (done4) begin
        ndone4++;
        if (lat4 == 0) lat4 = k;
      end
    end
    check("u4_latency", 64'(lat4),   64'd10);
    check("u4_ndone",   64'(ndone4), 64'd1);
    check("u4_result",  {32'h0, result4}, 64'h2345_6780);
    check("u4_rd_out",  {59'h0, rd_out4}, 64'd9);

    // Reset mid-operation.
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd4; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy4",   {63'h0, busy4},   64'd0);
    check("mid_rst_done4",   {63'h0, done4},   64'd0);
    check("mid_rst_result4", {32'h0, result4}, 64'd0);
    check("mid_rst_rd4",     {59'h0, rd_out4}, 64'd0);
    check("mid_rst_result",  {32'h0, result},  64'd0);
    reset = 1'b0;
    ndone4 = 0;
    repeat (15) begin
      @(negedge clk);
      if (done4) ndone4++;
    end
    check("no_done_after_rst", 64'(ndone4), 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the EX stage alongside the ALU. It holds the pipeline through a busy/stall handshake while it iterates, then returns the result and destination register for the EX/MEM register. Datapath width and bits-per-cycle are generalised.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
UNROLL, 1, quotient/product bits retired per cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
funct3  input  3  RISC-V M funct3 (000 MUL … 111 REMU)
op_a  input  XLEN  rs1 value (after forwarding)
op_b  input  XLEN  rs2 value (after forwarding)
rd_in  input  5  destination register
flush  input  1  abort current operation (branch/jump flush)
busy  output  1  operation in progress; pipeline must stall
done  output  1  one-cycle pulse, result valid
result  output  XLEN  operation result
rd_out  output  5  destination of completed operation

Behaviour:
- Reset values: busy=0, done=0, result=0, rd_out=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - If start && !flush, latch funct3, rd_in, |op_a|, |op_b| and the sign flags per op type. MULHSU: only op_a is signed; *U ops: neither operand is signed.
  - Then go to RUN with counter=XLEN/UNROLL and busy=1.
- RUN:
  - Multiply: shift-add, UNROLL bits per cycle, 2*XLEN accumulator.
  - Divide: restoring, UNROLL bits per cycle, XLEN remainder/quotient registers.
  - Counter decrements each cycle; at 1, go to FIX.
- FIX: apply sign correction (two's complement).
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the low half (MUL) or high half (MULH*), quotient (DIV*) or remainder (REM*).
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; result and rd_out registered; go to IDLE.
  - result and rd_out hold until the next DONE or reset.
- Latency: start sampled at edge T, done high in cycle T+XLEN/UNROLL+2. busy is high cycles T+1 .. T+XLEN/UNROLL+1.
- Upstream stall = busy | (start && state==IDLE).
- RISC-V corner cases are mandatory:
  - Divide by zero: quotient = all ones, remainder = op_a (unsigned and signed).
  - Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
  - Both cases still take full latency unless the optional feature is enabled.
- start while busy: ignored, no queuing.
- flush in RUN/FIX: return to IDLE next cycle, no done, result unchanged.
- flush in DONE: done still pulses (the instruction already completed).
- flush && start in IDLE: flush wins, nothing accepted.
- reset mid-operation: immediate return to the reset state at the next edge, no done.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - divide by zero, signed overflow, or either multiply operand zero skip RUN: IDLE→FIX→DONE, done at T+2.
  - Result values are identical to the non-early-out path.
- Undefined: every operation takes the fixed XLEN/UNROLL+2 latency; the early-out detection logic is absent.

Test Plan:
- XLEN=32, UNROLL=1, MUL op_a=7 op_b=0xFFFFFFFD, start at T → done at T+34, result=0xFFFFFFEB, rd_out=rd_in, busy high T+1..T+33.
- MULH 0x80000000*0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; DIVU 100/0 → 0xFFFFFFFF, REMU 100/0 → 100. Done at T+34, or T+2 with MULDIV_EARLY_OUT_EN.
- DIV 1000/10 started, flush at T+10 → busy low at T+11, no done. Next start at T+12 (MUL 3*4) → done at T+46, result=12.
- UNROLL=4 MUL 0x12345678*0x10 → done at T+10, result=0x23456780. start pulses while busy are ignored, exactly one done. reset at T+5 → all outputs 0 at T+6.
